// File: rtl/snake_move_ctrl.sv
// Snake game movement controller: steps the head across an 8x8 grid every
// TICK_DIV cycles, buffers one direction request, and stops at a wall.
module snake_move_ctrl #(
    parameter int         TICK_DIV  = 4,
    parameter logic [5:0] INIT_HEAD = 6'b011_011
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       btn_valid,
    input  logic [1:0] btn_dir,
    output logic [5:0] head,
    output logic [1:0] direction,
    output logic       move_pulse,
    output logic       colide,
    output logic [1:0] state,
    output logic [7:0] moves
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } state_t;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;
    localparam logic [7:0] LAST_TICK = 8'(TICK_DIV - 1);

    state_t     state_q, state_d;
    logic [5:0] head_d;
    logic [1:0] dir_d;
    logic [1:0] pend_q, pend_d;
    logic [7:0] tick_q, tick_d;
    logic [7:0] moves_d;
    logic       pulse_d;

    logic [2:0] row, col;
    logic       wall_hit;
    logic [5:0] stepped;

    assign row   = head[5:3];
    assign col   = head[2:0];
    assign state = state_q;

    // The candidate position may wrap, but it is only used when no wall is hit.
    always_comb begin
        wall_hit = 1'b0;
        stepped  = head;
        case (pend_q)
            DIR_RIGHT: begin wall_hit = (col == 3'd7); stepped = {row, col + 3'd1}; end
            DIR_DOWN:  begin wall_hit = (row == 3'd7); stepped = {row + 3'd1, col}; end
            DIR_LEFT:  begin wall_hit = (col == 3'd0); stepped = {row, col - 3'd1}; end
            DIR_UP:    begin wall_hit = (row == 3'd0); stepped = {row - 3'd1, col}; end
            default:   ;
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_d = state_q;
        head_d  = head;
        dir_d   = direction;
        pend_d  = pend_q;
        tick_d  = tick_q;
        moves_d = moves;
        pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                head_d  = INIT_HEAD;
                dir_d   = DIR_RIGHT;
                pend_d  = DIR_RIGHT;
                tick_d  = 8'd0;
                moves_d = 8'd0;
                if (start) state_d = RUN;
            end
            RUN: begin
                if (tick_q == LAST_TICK) begin
                    tick_d = 8'd0;
                    dir_d  = pend_q;
                    if (wall_hit) begin
                        state_d = OVER;
                    end else begin
                        head_d  = stepped;
                        pulse_d = 1'b1;
                        moves_d = moves + 8'd1;
                        if (pause) state_d = PAUSE;
                    end
                end else if (pause) begin
                    state_d = PAUSE;
                end else begin
                    tick_d = tick_q + 8'd1;
                end
                // Reversal is judged against the direction in force after this cycle's commit.
                if (btn_valid && (btn_dir != (dir_d ^ 2'b10))) pend_d = btn_dir;
            end
            PAUSE: begin
                if (pause) state_d = RUN;
            end
            OVER: begin
                if (start) begin
                    state_d = IDLE;
                    head_d  = INIT_HEAD;
                    dir_d   = DIR_RIGHT;
                    pend_d  = DIR_RIGHT;
                    tick_d  = 8'd0;
                    moves_d = 8'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            head       <= INIT_HEAD;
            direction  <= DIR_RIGHT;
            pend_q     <= DIR_RIGHT;
            tick_q     <= 8'd0;
            moves      <= 8'd0;
            move_pulse <= 1'b0;
            colide     <= 1'b0;
        end else begin
            state_q    <= state_d;
            head       <= head_d;
            direction  <= dir_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            moves      <= moves_d;
            move_pulse <= pulse_d;
            colide     <= (state_d == OVER);
        end
    end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Self-checking bench for snake_move_ctrl: directed scenarios with literal
// expectations plus randomized play checked every cycle against a grid model.
module tb_snake_move_ctrl;

    localparam int TICK_DIV = 4;

    logic       clock = 1'b0;
    logic       reset, start, pause, btn_valid;
    logic [1:0] btn_dir;
    logic [5:0] head;
    logic [1:0] direction;
    logic       move_pulse, colide;
    logic [1:0] state;
    logic [7:0] moves;

    int total = 0;
    int bad   = 0;

    snake_move_ctrl #(.TICK_DIV(TICK_DIV), .INIT_HEAD(6'b011_011)) dut (
        .clock(clock), .reset(reset), .start(start), .pause(pause),
        .btn_valid(btn_valid), .btn_dir(btn_dir), .head(head),
        .direction(direction), .move_pulse(move_pulse), .colide(colide),
        .state(state), .moves(moves)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Grid model: state as 0 idle / 1 run / 2 pause / 3 over, position as row/col.
    int m_state, m_row, m_col, m_dir, m_pend, m_tick, m_moves, m_pulse;
    int nr, nc;
    bit m_ok = 1'b0;
    int dr[4] = '{0, 1, 0, -1};
    int dc[4] = '{1, 0, -1, 0};

    task automatic model_idle();
        m_state = 0; m_row = 3; m_col = 3;
        m_dir = 0; m_pend = 0; m_tick = 0; m_moves = 0;
    endtask

    always @(posedge clock) begin
        m_pulse = 0;
        if (reset) begin
            m_ok = 1'b1;
            model_idle();
        end else if (m_ok) begin
            case (m_state)
                0: if (start) m_state = 1;
                1: begin
                    if (m_tick == TICK_DIV - 1) begin
                        m_tick = 0;
                        m_dir  = m_pend;
                        nr = m_row + dr[m_dir];
                        nc = m_col + dc[m_dir];
                        if (nr < 0 || nr > 7 || nc < 0 || nc > 7) begin
                            m_state = 3;
                        end else begin
                            m_row = nr; m_col = nc;
                            m_moves = (m_moves + 1) % 256;
                            m_pulse = 1;
                            if (pause) m_state = 2;
                        end
                    end else if (pause) begin
                        m_state = 2;
                    end else begin
                        m_tick++;
                    end
                    if (btn_valid && int'(btn_dir) != (m_dir + 2) % 4) m_pend = int'(btn_dir);
                end
                2: if (pause) m_state = 1;
                default: if (start) model_idle();
            endcase
        end
    end

    always @(negedge clock) begin
        if (m_ok) begin
            check("model_head",  int'(head),       m_row * 8 + m_col);
            check("model_dir",   int'(direction),  m_dir);
            check("model_pulse", int'(move_pulse), m_pulse);
            check("model_colide", int'(colide),    (m_state == 3) ? 1 : 0);
            check("model_state", int'(state),      m_state);
            check("model_moves", int'(moves),      m_moves);
        end
    end

    // Apply one cycle of inputs just after a falling edge; return at the next falling edge.
    task automatic cyc(input logic rs, input logic st, input logic pa,
                       input logic bv, input logic [1:0] bd);
        reset = rs; start = st; pause = pa; btn_valid = bv; btn_dir = bd;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic restart();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        check("reset_state", int'(state), 0);
        check("reset_head",  int'(head),  27);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        check("start_state", int'(state), 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; btn_valid = 1'b0; btn_dir = 2'b00;
        @(negedge clock);

        // Run right into the east wall.
        restart();
        check("reset_moves", int'(moves), 0);
        check("reset_colide", int'(colide), 0);
        for (int s = 1; s <= 4; s++) begin
            idle(3);
            check("pre_step_pulse", int'(move_pulse), 0);
            idle(1);
            check("step_head", int'(head), 27 + s);
            check("step_pulse", int'(move_pulse), 1);
        end
        idle(4);
        check("wall_state", int'(state), 3);
        check("wall_colide", int'(colide), 1);
        check("wall_head", int'(head), 31);
        check("wall_moves", int'(moves), 4);
        check("wall_pulse", int'(move_pulse), 0);

        // Leave OVER, then play again.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        check("over_start_state", int'(state), 0);
        check("over_start_colide", int'(colide), 0);
        check("over_start_head", int'(head), 27);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        check("restart_state", int'(state), 1);
        idle(4);
        check("restart_head", int'(head), 28);

        // Reversal dropped, then a turn down.
        restart();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
        idle(2);
        check("turn_down_head", int'(head), 35);
        check("turn_down_dir", int'(direction), 1);

        // Last accepted request wins.
        restart();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
        idle(2);
        check("last_wins_head", int'(head), 19);
        check("last_wins_dir", int'(direction), 3);

        // Pause at tick 2, resume, step two cycles later.
        restart();
        idle(2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        check("paused_state", int'(state), 2);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
            check("paused_head", int'(head), 27);
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        check("resume_state", int'(state), 1);
        idle(1);
        check("resume_no_step", int'(move_pulse), 0);
        idle(1);
        check("resume_step_head", int'(head), 28);
        check("resume_step_pulse", int'(move_pulse), 1);

        // Reset in a step cycle at head 29.
        restart();
        idle(8);
        check("pre_reset_head", int'(head), 29);
        idle(3);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        check("step_reset_head", int'(head), 27);
        check("step_reset_state", int'(state), 0);
        check("step_reset_pulse", int'(move_pulse), 0);
        check("step_reset_moves", int'(moves), 0);

        // Randomized play against the model.
        for (int i = 0; i < 4000; i++) begin
            cyc(logic'($urandom_range(0, 199) == 0),
                logic'($urandom_range(0, 7) == 0),
                logic'($urandom_range(0, 19) == 0),
                logic'($urandom_range(0, 2) == 0),
                2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
